pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage core. Drives the pause (bubble) inputs of the
//  if_id/id_ex/ex_mem/mem_wb registers and per-stage hold lines.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/flush sequencer for the 5-stage core.
//   Produces per-stage hold (stall_o) and bubble (pause_o) lines, tracks
//   multi-cycle data-memory waits with a timeout, defers EX redirects while
//   id_ex is held, and counts stalled cycles.
// Ports:
//   clk, rst            clock, async active-low reset
//   mem_req_i/ack_i     MEM-stage data access request / completion
//   stallreq_ex_i/id_i  EX busy / ID load-use
//   flush_req_i/pc_i    EX redirect pulse and target
//   cnt_clr_i           sync clear of stall_cnt_o
//   stall_o/pause_o     [0]PC [1]if_id [2]id_ex [3]ex_mem [4]mem_wb
//   flush_o/flush_pc_o  PC redirect this cycle
//   mem_abort_o/timeout_o  access abandoned after MEM_TIMEOUT cycles
//   stall_cnt_o         saturating count of cycles with any hold
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_id_i,
  input  logic             flush_req_i,
  input  logic [PC_W-1:0]  flush_pc_i,
  input  logic             cnt_clr_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       pause_o,
  output logic             flush_o,
  output logic [PC_W-1:0]  flush_pc_o,
  output logic             mem_abort_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_pend;
  logic [PC_W-1:0]  r_pend_pc;
  logic [CNT_W-1:0] r_stall_cnt;

  logic            w_timeout, w_mem, w_ex, w_id, w_hold, w_flush;
  logic [4:0]      w_stall, w_pause;
  logic [PC_W-1:0] w_fpc;

  always_comb begin
    w_timeout = (r_state == MEM_WAIT) & ~mem_ack_i &
                (r_wait_cnt == WCW'(MEM_TIMEOUT - 1));
    w_mem     = ~mem_ack_i & ((r_state == RUN) ? mem_req_i : ~w_timeout);
    w_ex      = ~w_mem & stallreq_ex_i;
    // id_ex held: a redirect cannot be taken yet
    w_hold    = w_mem | stallreq_ex_i;
    w_flush   = ~w_hold & (r_pend | flush_req_i);
    // a redirect discards the younger instructions, so load-use no longer matters
    w_id      = ~w_hold & ~w_flush & stallreq_id_i;
    w_fpc     = r_pend ? r_pend_pc : flush_pc_i;

    w_stall = 5'b00000;
    w_pause = 5'b00000;
    if (w_mem) begin
      w_stall = 5'b01111; w_pause = 5'b10000;
    end else if (w_ex) begin
      w_stall = 5'b00111; w_pause = 5'b01000;
    end else if (w_id) begin
      w_stall = 5'b00011; w_pause = 5'b00100;
    end
    // abandoned access: bubble the mem_wb slot instead of writing back
    if (w_timeout) w_pause[4]   = 1'b1;
    if (w_flush)   w_pause[2:1] = 2'b11;
  end

  // outputs forced quiet while reset is asserted
  assign stall_o     = rst ? w_stall : 5'b00000;
  assign pause_o     = rst ? w_pause : 5'b00000;
  assign flush_o     = rst & w_flush;
  assign flush_pc_o  = (rst & w_flush) ? w_fpc : '0;
  assign timeout_o   = rst & w_timeout;
  assign mem_abort_o = rst & w_timeout;
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_pend      <= 1'b0;
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        RUN: if (mem_req_i & ~mem_ack_i) begin
          r_state    <= MEM_WAIT;
          r_wait_cnt <= WCW'(1);
        end
        MEM_WAIT: if (mem_ack_i | w_timeout) begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
        default: r_state <= RUN;
      endcase

      // an issuing pend swallows a coincident request
      if (w_flush) r_pend <= 1'b0;
      else if (flush_req_i) begin
        r_pend    <= 1'b1;
        r_pend_pc <= flush_pc_i;
      end

      if (cnt_clr_i)                      r_stall_cnt <= '0;
      else if ((|w_stall) & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of the sequencer.
module tb_pipe_ctrl;
  localparam int TO = 8, CW = 4, PW = 16;

  logic          clk = 1'b0, rst = 1'b0;
  logic          req, ack, ex, id, freq, clr;
  logic [PW-1:0] fpc_in;
  logic [4:0]    stall_o, pause_o;
  logic          flush_o, mem_abort_o, timeout_o;
  logic [PW-1:0] flush_pc_o;
  logic [CW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .mem_req_i(req), .mem_ack_i(ack),
    .stallreq_ex_i(ex), .stallreq_id_i(id), .flush_req_i(freq),
    .flush_pc_i(fpc_in), .cnt_clr_i(clr), .stall_o(stall_o), .pause_o(pause_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .mem_abort_o(mem_abort_o),
    .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o));

  wire [32:0] obs = {stall_o, pause_o, flush_o, flush_pc_o, timeout_o, mem_abort_o, stall_cnt_o};

  // model state: whether an access is outstanding and how many cycles it has used
  bit            m_wait, m_pend;
  int            m_used;
  logic [PW-1:0] m_pc;
  logic [CW-1:0] m_cnt;
  logic [32:0]   exp_v;
  bit            e_flush;
  logic [4:0]    e_stall;
  int            n_chk = 0, n_pass = 0;

  task automatic model_reset();
    m_wait = 0; m_used = 0; m_pend = 0; m_pc = '0; m_cnt = '0;
  endtask

  task automatic model_eval();
    bit to, mem, fl;
    logic [4:0] s, p;
    logic [PW-1:0] pc;
    to  = m_wait && !ack && (m_used + 1 == TO);   // this would be access cycle TO
    mem = !ack && (m_wait ? !to : req);
    fl  = !(mem || ex) && (m_pend || freq);
    if (mem)             begin s = 5'b01111; p = 5'b10000; end
    else if (ex)         begin s = 5'b00111; p = 5'b01000; end
    else if (id && !fl)  begin s = 5'b00011; p = 5'b00100; end
    else                 begin s = 5'b00000; p = 5'b00000; end
    if (to) p[4] = 1'b1;
    if (fl) p[2:1] = 2'b11;
    pc = !fl ? '0 : (m_pend ? m_pc : fpc_in);
    e_flush = fl; e_stall = s;
    exp_v = {s, p, fl, pc, to, to, m_cnt};
  endtask

  task automatic model_tick();
    if (clr) m_cnt = '0;
    else if (|e_stall && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (!m_wait) begin
      if (req && !ack) begin m_wait = 1; m_used = 1; end
    end else if (ack || m_used + 1 == TO) begin
      m_wait = 0; m_used = 0;
    end else m_used++;
    if (e_flush) m_pend = 0;
    else if (freq) begin m_pend = 1; m_pc = fpc_in; end
  endtask

  task automatic idle_in();
    req = 0; ack = 0; ex = 0; id = 0; freq = 0; clr = 0; fpc_in = '0;
  endtask

  task automatic settle();
    #1 model_eval();
  endtask

  task automatic advance();
    @(posedge clk); model_tick(); @(negedge clk);
  endtask

  task automatic test_reset();
    req = 1; ex = 1; id = 1; freq = 1; fpc_in = 16'h1234; ack = 0; clr = 0;
    #2;
    n_chk++;
    if (obs !== 33'd0) $display("FAIL reset_outputs got %h want 0", obs);
    else n_pass++;
    @(negedge clk); idle_in(); rst = 1; model_reset();
    settle();
    n_chk++;
    if (obs !== exp_v) $display("FAIL reset_release got %h want %h", obs, exp_v);
    else n_pass++;
    advance();
  endtask

  task automatic test_mem_ack();
    for (int i = 0; i < 5; i++) begin
      req = (i < 4); ack = (i == 3);
      settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL mem_ack c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      if (i < 3) begin
        n_chk++;
        if ({stall_o, pause_o} !== 10'b01111_10000)
          $display("FAIL mem_ack_enc c%0d got %b_%b want 01111_10000", i, stall_o, pause_o);
        else n_pass++;
      end
      advance();
    end
    idle_in();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 9; i++) begin
      req = (i < 8); ack = 0;
      settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL timeout c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      if (i == 7) begin
        n_chk++;
        if ({stall_o, pause_o, timeout_o, mem_abort_o} !== 12'b00000_10000_11)
          $display("FAIL timeout_pulse got %b_%b_%b%b want 00000_10000_11",
                   stall_o, pause_o, timeout_o, mem_abort_o);
        else n_pass++;
      end
      advance();
    end
    idle_in();
  endtask

  task automatic test_ex_id();
    for (int i = 0; i < 3; i++) begin
      ex = (i == 0); id = (i < 2);
      settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL ex_id c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      n_chk++;
      if (i == 0 && {stall_o, pause_o} !== 10'b00111_01000)
        $display("FAIL ex_enc got %b_%b want 00111_01000", stall_o, pause_o);
      else if (i == 1 && {stall_o, pause_o} !== 10'b00011_00100)
        $display("FAIL id_enc got %b_%b want 00011_00100", stall_o, pause_o);
      else n_pass++;
      advance();
    end
    idle_in();
  endtask

  task automatic test_flush_pend();
    for (int i = 0; i < 5; i++) begin
      req = (i < 4); ack = (i == 3); freq = (i == 0); fpc_in = (i == 0) ? 16'h0040 : 16'h0bad;
      settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL flush_pend c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      n_chk++;
      if (i < 3 && flush_o !== 1'b0)
        $display("FAIL flush_held c%0d got %b want 0", i, flush_o);
      else if (i == 3 && {flush_o, flush_pc_o, pause_o} !== {1'b1, 16'h0040, 5'b00110})
        $display("FAIL flush_issue got %b %h %b want 1 0040 00110", flush_o, flush_pc_o, pause_o);
      else n_pass++;
      advance();
    end
    idle_in();
  endtask

  task automatic test_flush_id();
    freq = 1; id = 1; fpc_in = 16'($urandom);
    settle();
    n_chk++;
    if (obs !== exp_v) $display("FAIL flush_id got %h want %h", obs, exp_v);
    else n_pass++;
    n_chk++;
    if ({flush_o, flush_pc_o, stall_o, pause_o} !== {1'b1, fpc_in, 5'b00000, 5'b00110})
      $display("FAIL flush_beats_id got %b %h %b %b want 1 %h 00000 00110",
               flush_o, flush_pc_o, stall_o, pause_o, fpc_in);
    else n_pass++;
    advance();
    idle_in();
  endtask

  task automatic test_cnt_sat();
    clr = 1; settle(); advance(); clr = 0;
    for (int i = 0; i < 20; i++) begin
      ex = 1; settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL cnt c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      advance();
    end
    settle();
    n_chk++;
    if (stall_cnt_o !== 4'd15) $display("FAIL cnt_sat got %0d want 15", stall_cnt_o);
    else n_pass++;
    clr = 1; advance(); clr = 0; ex = 0;
    settle();
    n_chk++;
    if (stall_cnt_o !== 4'd0) $display("FAIL cnt_clr got %0d want 0", stall_cnt_o);
    else n_pass++;
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 2) != 0); ack = ($urandom_range(0, 4) == 0);
      ex = ($urandom_range(0, 5) == 0); id = ($urandom_range(0, 3) == 0);
      freq = ($urandom_range(0, 6) == 0); fpc_in = 16'($urandom);
      clr = ($urandom_range(0, 30) == 0);
      settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL random c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      advance();
    end
    idle_in();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      req = 1; ex = (i == 2); freq = (i == 1); fpc_in = 16'h0777;
      settle(); advance();
    end
    #2 rst = 0;
    #1;
    n_chk++;
    if (obs !== 33'd0) $display("FAIL reset_mid got %h want 0", obs);
    else n_pass++;
    @(negedge clk); idle_in(); rst = 1; model_reset();
    for (int i = 0; i < 2; i++) begin
      req = (i == 1);
      settle();
      n_chk++;
      if (obs !== exp_v) $display("FAIL after_reset c%0d got %h want %h", i, obs, exp_v);
      else n_pass++;
      advance();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    model_reset();
    @(negedge clk);
    test_reset();
    test_mem_ack();
    test_timeout();
    test_ex_id();
    test_flush_pend();
    test_flush_id();
    test_cnt_sat();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
